// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx
// Brief   : 16x-oversampled UART receiver with frame-error and break handling
// Revision: 1.0
// ============================================================================
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       s_tick,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err_tick,
  output logic       busy
);

  localparam int SW    = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW    = 3;
  localparam int SHIFT = 8 - DBIT;

  localparam logic [SW-1:0] C_S_MID  = SW'(7);
  localparam logic [SW-1:0] C_S_LAST = SW'(15);
  localparam logic [SW-1:0] C_S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] C_N_LAST = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [7:0]      b_q, b_d;
  logic [7:0]      dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            rx_meta_q, rx_s_q;

  // Synchronizer flops reset to the idle line level so reset never looks like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == C_S_MID) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == C_S_LAST) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[7:1]};
            if (n_q == C_N_LAST) state_d = STOP;
            else                 n_d     = n_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == C_S_STOP) begin
            if (rx_s_q) begin
              // Short frames land in the top DBIT bits; right-align them
              dout_d  = b_q >> SHIFT;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BREAK;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      BREAK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout           = dout_q;
  assign rx_done_tick   = done_q;
  assign frame_err_tick = ferr_q;
  assign busy           = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx
// Brief   : Self-checking bench for uart_rx (table, directed and random frames)
// Revision: 1.0
// ============================================================================
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx1 = 1'b1;
  logic       rx2 = 1'b1;
  logic       s_tick;
  logic [7:0] dout1, dout2;
  logic       done1, done2, ferr1, ferr2, busy1, busy2;

  int tickdiv = 4;
  int tcnt    = 0;
  int cyc     = 0;
  int checks  = 0;
  int errors  = 0;

  int n_done1 = 0, n_ferr1 = 0, n_done2 = 0, n_ferr2 = 0, n_excl = 0;
  int last_done_cyc2 = 0;
  logic prev1 = 1'b0, prev2 = 1'b0;
  logic [7:0] q1[$];

  uart_rx #(.DBIT(8), .SB_TICK(16)) u_dut8 (
    .clk(clk), .rst(rst), .rx(rx1), .s_tick(s_tick), .dout(dout1),
    .rx_done_tick(done1), .frame_err_tick(ferr1), .busy(busy1)
  );

  uart_rx #(.DBIT(7), .SB_TICK(32)) u_dut7 (
    .clk(clk), .rst(rst), .rx(rx2), .s_tick(s_tick), .dout(dout2),
    .rx_done_tick(done2), .frame_err_tick(ferr2), .busy(busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tcnt >= tickdiv - 1) tcnt <= 0;
    else                     tcnt <= tcnt + 1;
  end
  assign s_tick = (tcnt == 0);

  // Pulse monitor: counts ticks, logs received bytes, flags overlapping/adjacent pulses
  always @(negedge clk) begin
    if (done1) begin n_done1++; q1.push_back(dout1); end
    if (ferr1) n_ferr1++;
    if (done2) begin n_done2++; last_done_cyc2 = cyc; end
    if (ferr2) n_ferr2++;
    if ((done1 && ferr1) || (done2 && ferr2)) n_excl++;
    if (((done1 || ferr1) && prev1) || ((done2 || ferr2) && prev2)) n_excl++;
    prev1 = done1 | ferr1;
    prev2 = done2 | ferr2;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit which, input logic v, input int clks);
    if (which) rx2 = v;
    else       rx1 = v;
    wait_clk(clks);
  endtask

  task automatic send(input bit which, input logic [7:0] d, input int nbits,
                      input int nstop, input logic stopv);
    int bp;
    bp = 16 * tickdiv;
    drive(which, 1'b0, bp);
    for (int i = 0; i < nbits; i++) drive(which, d[i], bp);
    for (int i = 0; i < nstop; i++) drive(which, stopv, bp);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_done;
    int         exp_ferr;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int d0, f0, c0, lat, ok;
    logic [7:0] model_dout, a0, a1, data;
    logic stopv;

    tbl[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
    tbl[1] = '{8'h3C, 1'b0, 0, 1, 8'hA5};
    tbl[2] = '{8'h00, 1'b1, 1, 0, 8'h00};
    tbl[3] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
    tbl[4] = '{8'h81, 1'b1, 1, 0, 8'h81};

    // Reset state
    wait_clk(3);
    @(negedge clk);
    chk("rst_dout", dout1, 8'h00);
    chk("rst_done", done1, 1'b0);
    chk("rst_ferr", ferr1, 1'b0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_dout2", dout2, 8'h00);
    wait_clk(1);
    rst = 1'b0;
    wait_clk(10);

    // Table-driven frames on the 8-bit instance
    for (int i = 0; i < 5; i++) begin
      d0 = n_done1; f0 = n_ferr1;
      send(0, tbl[i].data, 8, 1, tbl[i].stop);
      if (!tbl[i].stop) wait_clk(500);
      rx1 = 1'b1;
      wait_clk(64);
      @(negedge clk);
      chk($sformatf("tbl%0d_done", i), n_done1 - d0, tbl[i].exp_done);
      chk($sformatf("tbl%0d_ferr", i), n_ferr1 - f0, tbl[i].exp_ferr);
      chk($sformatf("tbl%0d_dout", i), dout1, tbl[i].exp_dout);
      chk($sformatf("tbl%0d_busy", i), busy1, 1'b0);
    end

    // Glitch on the line shorter than half a bit
    d0 = n_done1; f0 = n_ferr1;
    rx1 = 1'b0;
    wait_clk(6);
    chk("glitch_busy_hi", busy1, 1'b1);
    wait_clk(3 * tickdiv - 6);
    rx1 = 1'b1;
    wait_clk(100);
    @(negedge clk);
    chk("glitch_done", n_done1 - d0, 0);
    chk("glitch_ferr", n_ferr1 - f0, 0);
    chk("glitch_dout", dout1, 8'h81);
    chk("glitch_busy", busy1, 1'b0);

    // Reset in the middle of DATA bit 4 of 0xFF
    d0 = n_done1; f0 = n_ferr1;
    drive(0, 1'b0, 64);
    for (int i = 0; i < 4; i++) drive(0, 1'b1, 64);
    wait_clk(32);
    chk("midrst_busy_hi", busy1, 1'b1);
    rst = 1'b1;
    wait_clk(3);
    @(negedge clk);
    chk("midrst_dout", dout1, 8'h00);
    chk("midrst_busy", busy1, 1'b0);
    wait_clk(1);
    rst = 1'b0;
    wait_clk(5 * 64);
    chk("midrst_nopulse", (n_done1 - d0) + (n_ferr1 - f0), 0);
    send(0, 8'h5A, 8, 1, 1'b1);
    wait_clk(64);
    @(negedge clk);
    chk("postrst_done", n_done1 - d0, 1);
    chk("postrst_dout", dout1, 8'h5A);

    // Back-to-back frames with no idle gap
    q1.delete();
    send(0, 8'h00, 8, 1, 1'b1);
    send(0, 8'hFF, 8, 1, 1'b1);
    wait_clk(64);
    @(negedge clk);
    a0 = (q1.size() > 0) ? q1[0] : 8'hxx;
    a1 = (q1.size() > 1) ? q1[1] : 8'hxx;
    chk("b2b_count", q1.size(), 2);
    chk("b2b_first", a0, 8'h00);
    chk("b2b_second", a1, 8'hFF);

    // 7 data bits, two stop bits on the second instance
    d0 = n_done2; f0 = n_ferr2;
    c0 = cyc;
    send(1, 8'h55, 7, 2, 1'b1);
    rx2 = 1'b1;
    wait_clk(64);
    @(negedge clk);
    chk("d7_done", n_done2 - d0, 1);
    chk("d7_ferr", n_ferr2 - f0, 0);
    chk("d7_dout", dout2, 8'h55);
    lat = last_done_cyc2 - c0;
    ok = (lat >= 9 * 64 + 16 && lat <= 9 * 64 + 52) ? 1 : 0;
    if (!ok) $display("done2 latency %0d clk", lat);
    chk("d7_done_in_2nd_stop_mid", ok, 1);

    // Random frames, random tick ratio, against a frame-level model
    model_dout = dout1;
    for (int k = 0; k < 20; k++) begin
      tickdiv = $urandom_range(2, 6);
      wait_clk(10);
      data  = 8'($urandom);
      stopv = ($urandom_range(0, 4) != 0);
      d0 = n_done1; f0 = n_ferr1;
      send(0, data, 8, 1, stopv);
      if (!stopv) wait_clk($urandom_range(0, 300));
      rx1 = 1'b1;
      wait_clk(16 * tickdiv + $urandom_range(0, 40));
      if (stopv) model_dout = data;
      @(negedge clk);
      chk($sformatf("rnd%0d_done", k), n_done1 - d0, stopv ? 1 : 0);
      chk($sformatf("rnd%0d_ferr", k), n_ferr1 - f0, stopv ? 0 : 1);
      chk($sformatf("rnd%0d_dout", k), dout1, model_dout);
    end

    chk("pulse_exclusive", n_excl, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter DBIT, default 8, number of data bits per frame (5..8).
REQ-002 SHALL provide parameter SB_TICK, default 16, oversample ticks per stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 SHALL provide port clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL provide port s_tick  input  1  one-clk pulse at 16x baud, from the baud generator.
REQ-007 SHALL provide port dout  output  8  last correctly received byte, LSB-aligned; unused upper bits 0 when DBIT<8.
REQ-008 SHALL provide port rx_done_tick  output  1  one-clk pulse; dout newly valid, consumed as the RX FIFO write enable.
REQ-009 SHALL provide port frame_err_tick  output  1  one-clk pulse; stop bit sampled low, byte discarded.
REQ-010 SHALL provide port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer, both flops reset to 1; the result (rx_s) is the only rx used internally; pin-to-rx_s latency is 2 clk.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, BREAK, using an oversample counter s and a bit counter n, each wide enough for its maximum value.
REQ-013 IDLE: s_tick SHALL be ignored; when rx_s==0, the block SHALL go to START with s=0.
REQ-014 START: on each s_tick, if s==7 and rx_s==0, the block SHALL go to DATA with s=0 and n=0.
REQ-015 START: on each s_tick, if s==7 and rx_s==1 (glitch), the block SHALL go to IDLE with no output pulse.
REQ-016 START: on each s_tick with s<7, the block SHALL increment s.
REQ-017 DATA: on s_tick with s==15, the block SHALL shift rx_s into the MSB of an internal shift register (right shift, LSB-first line order) and set s=0.
REQ-018 DATA: after the sample in REQ-017, if n==DBIT-1 the block SHALL go to STOP; otherwise it SHALL increment n.
REQ-019 DATA: on s_tick with s<15, the block SHALL increment s.
REQ-020 STOP: on s_tick with s==SB_TICK-1, if rx_s==1, the block SHALL load dout with the shift register right-aligned by 8-DBIT, pulse rx_done_tick for exactly 1 clk, and go to IDLE.
REQ-021 STOP: on s_tick with s==SB_TICK-1, if rx_s==0, the block SHALL pulse frame_err_tick for 1 clk, leave dout unchanged, and go to BREAK.
REQ-022 BREAK: the block SHALL stay in BREAK until rx_s==1, then go to IDLE; a held-low line therefore yields exactly one frame_err_tick.
REQ-023 rx_done_tick and frame_err_tick SHALL be mutually exclusive and never high in consecutive cycles from the same frame.
REQ-024 A new start bit SHALL be accepted in the clk cycle after return to IDLE, so back-to-back frames are received with no idle gap required.
REQ-025 Counters SHALL advance only on s_tick; the clk-to-s_tick ratio SHALL NOT affect results.

Reset
REQ-026 On rst the block SHALL force state=IDLE, s=0, n=0, shift register=0, dout=8'h00, rx_done_tick=0, frame_err_tick=0, busy=0, and both synchronizer flops=1.
REQ-027 Assertion of rst mid-frame SHALL abort the frame with no output pulse; after release, the next start bit SHALL be received normally.

Verification
REQ-028 s_tick every 4 clk (64 clk per bit), DBIT=8, SB_TICK=16, send 8'hA5 with a valid stop bit -> exactly one rx_done_tick, dout=8'hA5, frame_err_tick never high, busy low afterwards.
REQ-029 rx low for 3 s_ticks then high -> START aborts to IDLE, no pulse on either tick output, dout unchanged.
REQ-030 Send 8'h3C with stop bit 0, then hold rx low for 500 clk, then raise rx -> exactly one frame_err_tick, no rx_done_tick, dout keeps its previous value, block in IDLE after rx rises.
REQ-031 Assert rst during DATA bit 4 of 8'hFF, release, then send 8'h5A -> dout=8'h00 after reset, then one rx_done_tick with dout=8'h5A.
REQ-032 Back-to-back 8'h00 then 8'hFF with no idle between frames -> two rx_done_ticks, in order dout=8'h00 then 8'hFF.
REQ-033 DBIT=7, SB_TICK=32, send 7'h55 with two stop bits -> dout=8'h55, one rx_done_tick issued in the middle of the second stop bit.
